// File: rtl/resa_pe_vec_if.sv
// Streaming datapath bundle of one ReSA PE: valid-tagged operand inputs,
// pass-through outputs and the partial-sum / drain lane.
interface resa_pe_vec_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACCUM_WIDTH = 32,
  parameter int unsigned LANES       = 2
);
  localparam int unsigned VEC_WIDTH = LANES * DATA_WIDTH;

  logic                   in_valid;
  logic [VEC_WIDTH-1:0]   input_0;
  logic [ACCUM_WIDTH-1:0] input_1;
  logic [VEC_WIDTH-1:0]   input_2;
  logic [VEC_WIDTH-1:0]   output_0;
  logic [ACCUM_WIDTH-1:0] output_1;
  logic [VEC_WIDTH-1:0]   output_2;
  logic                   out_valid;
  logic                   psum_valid;

  modport master (
    output in_valid, input_0, input_1, input_2,
    input  output_0, output_1, output_2, out_valid, psum_valid
  );

  modport slave (
    input  in_valid, input_0, input_1, input_2,
    output output_0, output_1, output_2, out_valid, psum_valid
  );
endinterface

// File: rtl/resa_pe_vec.sv
// Reconfigurable systolic PE (WS/IS/OS) with a LANES-wide signed dot product,
// double-buffered stationary operand, optional saturation and OS drain chain.
module resa_pe_vec #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACCUM_WIDTH = 32,
  parameter int unsigned LANES       = 2,
  parameter bit          SATURATE    = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  dataflow_sel,
  input  logic                        preload_en,
  input  logic [LANES*DATA_WIDTH-1:0] preload_data,
  input  logic                        buf_swap,
  input  logic                        acc_clr,
  input  logic                        drain_en,
  resa_pe_vec_if.slave                pe,
  output logic                        sat_flag
);
  localparam int unsigned VEC_WIDTH = LANES * DATA_WIDTH;
  localparam int unsigned WIDE      = ACCUM_WIDTH + $clog2(LANES) + 1;
  localparam int unsigned PROD_W    = 2 * DATA_WIDTH;

  localparam logic signed [WIDE-1:0] SUM_MAX =
    signed'(WIDE'({1'b0, {(ACCUM_WIDTH-1){1'b1}}}));
  localparam logic signed [WIDE-1:0] SUM_MIN = ~SUM_MAX;

  typedef enum logic [1:0] {
    MODE_WS   = 2'b00,
    MODE_IS   = 2'b01,
    MODE_OS   = 2'b10,
    MODE_IDLE = 2'b11
  } mode_e;

  mode_e                  mode_q, mode_cur;
  logic [VEC_WIDTH-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic [ACCUM_WIDTH-1:0] acc_q, acc_d;
  logic [VEC_WIDTH-1:0]   out0_q, out0_d, out2_q, out2_d;
  logic [ACCUM_WIDTH-1:0] out1_q, out1_d;
  logic                   ov_q, ov_d, pv_q, pv_d, sat_q, sat_d;

  logic [VEC_WIDTH-1:0]   mac_a;
  logic [ACCUM_WIDTH-1:0] mac_add, mac_res;
  logic                   mac_ovf, mode_chg;

  // Exact dot product plus addend at WIDE bits, then clamp or wrap; MSB = overflow.
  function automatic logic [ACCUM_WIDTH:0] mac_f(
    input logic [VEC_WIDTH-1:0]   a,
    input logic [VEC_WIDTH-1:0]   b,
    input logic [ACCUM_WIDTH-1:0] add
  );
    logic signed [WIDE-1:0]       s;
    logic signed [DATA_WIDTH-1:0] ai, bi;
    logic signed [PROD_W-1:0]     p;
    logic                         ovf;
    logic [ACCUM_WIDTH-1:0]       r;
    s = WIDE'(signed'(add));
    for (int unsigned i = 0; i < LANES; i++) begin
      ai = signed'(a[i*DATA_WIDTH +: DATA_WIDTH]);
      bi = signed'(b[i*DATA_WIDTH +: DATA_WIDTH]);
      p  = ai * bi;
      s  = s + WIDE'(p);
    end
    ovf = (s > SUM_MAX) || (s < SUM_MIN);
    if (ovf && SATURATE)
      r = s[WIDE-1] ? ACCUM_WIDTH'(SUM_MIN) : ACCUM_WIDTH'(SUM_MAX);
    else
      r = s[ACCUM_WIDTH-1:0];
    return {ovf, r};
  endfunction

  // Next-state and output computation for every register in the PE.
  always_comb begin
    mode_cur = mode_e'(dataflow_sel);
    mode_chg = (mode_cur != mode_q);
    mac_a    = (mode_cur == MODE_OS) ? pe.input_0 : active_q;
    mac_add  = (mode_cur == MODE_OS) ? acc_q : pe.input_1;
    {mac_ovf, mac_res} = mac_f(mac_a, pe.input_2, mac_add);

    shadow_d = shadow_q;
    active_d = active_q;
    acc_d    = acc_q;
    out0_d   = '0;
    out1_d   = '0;
    out2_d   = '0;
    ov_d     = 1'b0;
    pv_d     = 1'b0;
    sat_d    = sat_q;

    if (preload_en) shadow_d = preload_data;
    if (buf_swap)   active_d = shadow_q;

    case (mode_cur)
      MODE_WS, MODE_IS: begin
        ov_d   = pe.in_valid;
        out2_d = pe.in_valid ? pe.input_2 : '0;
        if (acc_clr) sat_d = 1'b0;
        if (acc_clr || mode_chg) acc_d = '0;
        if (pe.in_valid) begin
          out1_d = mac_res;
          pv_d   = 1'b1;
          if (mac_ovf) sat_d = 1'b1;
        end
      end
      MODE_OS: begin
        ov_d   = pe.in_valid;
        out0_d = pe.in_valid ? pe.input_0 : '0;
        out2_d = pe.in_valid ? pe.input_2 : '0;
        // Drain shifts the column; clear and mode change both drop the MAC.
        if (drain_en) begin
          out1_d = acc_q;
          pv_d   = 1'b1;
          acc_d  = pe.input_1;
        end else if (acc_clr || mode_chg) begin
          acc_d = '0;
          if (acc_clr) sat_d = 1'b0;
        end else if (pe.in_valid) begin
          acc_d = mac_res;
          if (mac_ovf) sat_d = 1'b1;
        end
      end
      default: begin
        if (acc_clr) sat_d = 1'b0;
        if (acc_clr || mode_chg) acc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_WS;
      shadow_q <= '0;
      active_q <= '0;
      acc_q    <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
      out2_q   <= '0;
      ov_q     <= 1'b0;
      pv_q     <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      mode_q   <= mode_cur;
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      ov_q     <= ov_d;
      pv_q     <= pv_d;
      sat_q    <= sat_d;
    end
  end

  assign pe.output_0   = out0_q;
  assign pe.output_1   = out1_q;
  assign pe.output_2   = out2_q;
  assign pe.out_valid  = ov_q;
  assign pe.psum_valid = pv_q;
  assign sat_flag      = sat_q;
endmodule

// File: tb/tb_resa_pe_vec.sv
// Bench for resa_pe_vec: a 2-PE OS column (saturating) plus a wrapping PE,
// checked against an arithmetic reference model and directed test-plan values.
module tb_resa_pe_vec;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned L  = 2;
  localparam int unsigned VW = L * DW;
  localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (AW - 1));

  typedef struct {
    logic [VW-1:0] shadow, active, out0, out2;
    logic [AW-1:0] acc, out1;
    logic          ov, pv, sat;
    logic [1:0]    mode;
  } pe_t;

  typedef struct {
    logic [1:0]    sel;
    logic          pre_en, swap, iv, clr, drain;
    logic [VW-1:0] pre_data, i0, i2;
    logic [AW-1:0] i1;
  } in_t;

  bit clk = 1'b0;
  logic rst;
  logic [1:0] sel;
  logic pre_en, swap, clr, drain0, drain1, iv;
  logic [VW-1:0] pre_data, i0, i2;
  logic [AW-1:0] i1;
  logic sat0, sat1, sat2;
  int tests = 0;
  int fails = 0;
  pe_t m0, m1, m2;

  always #5 clk = ~clk;

  resa_pe_vec_if #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(L)) if0 ();
  resa_pe_vec_if #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(L)) if1 ();
  resa_pe_vec_if #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(L)) if2 ();

  assign if0.in_valid = iv;
  assign if0.input_0  = i0;
  assign if0.input_1  = i1;
  assign if0.input_2  = i2;
  assign if1.in_valid = iv;
  assign if1.input_0  = i0;
  assign if1.input_1  = if0.output_1;
  assign if1.input_2  = i2;
  assign if2.in_valid = iv;
  assign if2.input_0  = i0;
  assign if2.input_1  = i1;
  assign if2.input_2  = i2;

  resa_pe_vec #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(L), .SATURATE(1'b1)) u0 (
    .clk(clk), .rst(rst), .dataflow_sel(sel), .preload_en(pre_en), .preload_data(pre_data),
    .buf_swap(swap), .acc_clr(clr), .drain_en(drain0), .pe(if0), .sat_flag(sat0));
  resa_pe_vec #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(L), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .dataflow_sel(sel), .preload_en(pre_en), .preload_data(pre_data),
    .buf_swap(swap), .acc_clr(clr), .drain_en(drain1), .pe(if1), .sat_flag(sat1));
  resa_pe_vec #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(L), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst), .dataflow_sel(sel), .preload_en(pre_en), .preload_data(pre_data),
    .buf_swap(swap), .acc_clr(clr), .drain_en(drain0), .pe(if2), .sat_flag(sat2));

  function automatic logic [VW-1:0] pk(input int e0, input int e1);
    return {DW'(e1), DW'(e0)};
  endfunction

  // Signed dot product + addend in 64-bit arithmetic; MSB of the result flags overflow.
  function automatic logic [AW:0] mac_m(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                        input logic [AW-1:0] add, input bit satm);
    longint s;
    logic signed [DW-1:0] ea, eb;
    logic [AW-1:0] r;
    bit ovf;
    s = longint'(signed'(add));
    for (int i = 0; i < L; i++) begin
      ea = a[i*DW +: DW];
      eb = b[i*DW +: DW];
      s  = s + longint'(ea) * longint'(eb);
    end
    ovf = (s > MAXV) || (s < MINV);
    r = s[AW-1:0];
    if (ovf && satm) r = (s > 0) ? AW'(MAXV) : AW'(MINV);
    return {ovf, r};
  endfunction

  function automatic pe_t step(input pe_t s, input in_t x, input bit satm);
    pe_t n;
    bit os, act, chg;
    logic [AW:0] m;
    n = s;
    os  = (x.sel == 2'b10);
    act = (x.sel != 2'b11);
    chg = (x.sel != s.mode);
    n.mode = x.sel;
    if (x.pre_en) n.shadow = x.pre_data;
    if (x.swap)   n.active = s.shadow;
    n.ov   = act && x.iv;
    n.out2 = (act && x.iv) ? x.i2 : '0;
    n.out0 = (os && x.iv) ? x.i0 : '0;
    n.out1 = '0;
    n.pv   = 1'b0;
    if (os) begin
      if (x.drain) begin
        n.out1 = s.acc; n.pv = 1'b1; n.acc = x.i1;
      end else if (x.clr || chg) begin
        n.acc = '0;
        if (x.clr) n.sat = 1'b0;
      end else if (x.iv) begin
        m = mac_m(x.i0, x.i2, s.acc, satm);
        n.acc = m[AW-1:0];
        if (m[AW]) n.sat = 1'b1;
      end
    end else begin
      if (x.clr) n.sat = 1'b0;
      if (x.clr || chg) n.acc = '0;
      if (act && x.iv) begin
        m = mac_m(s.active, x.i2, x.i1, satm);
        n.out1 = m[AW-1:0]; n.pv = 1'b1;
        if (m[AW]) n.sat = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic in_t cur_in(input logic dr, input logic [AW-1:0] in1);
    in_t x;
    x.sel = sel; x.pre_en = pre_en; x.pre_data = pre_data; x.swap = swap;
    x.iv = iv; x.i0 = i0; x.i1 = in1; x.i2 = i2; x.clr = clr; x.drain = dr;
    return x;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("u0_out0", 64'(if0.output_0), 64'(m0.out0));
    cmp("u0_out1", 64'(if0.output_1), 64'(m0.out1));
    cmp("u0_out2", 64'(if0.output_2), 64'(m0.out2));
    cmp("u0_ovpv", 64'({if0.out_valid, if0.psum_valid, sat0}), 64'({m0.ov, m0.pv, m0.sat}));
    cmp("u1_out0", 64'(if1.output_0), 64'(m1.out0));
    cmp("u1_out1", 64'(if1.output_1), 64'(m1.out1));
    cmp("u1_out2", 64'(if1.output_2), 64'(m1.out2));
    cmp("u1_ovpv", 64'({if1.out_valid, if1.psum_valid, sat1}), 64'({m1.ov, m1.pv, m1.sat}));
    cmp("u2_out0", 64'(if2.output_0), 64'(m2.out0));
    cmp("u2_out1", 64'(if2.output_1), 64'(m2.out1));
    cmp("u2_out2", 64'(if2.output_2), 64'(m2.out2));
    cmp("u2_ovpv", 64'({if2.out_valid, if2.psum_valid, sat2}), 64'({m2.ov, m2.pv, m2.sat}));
  endtask

  // One clock: models advance on the edge, DUT is sampled 1 time unit later.
  task automatic tick();
    in_t x0, x1, x2;
    x0 = cur_in(drain0, i1);
    x1 = cur_in(drain1, m0.out1);
    x2 = cur_in(drain0, i1);
    @(posedge clk);
    m0 = step(m0, x0, 1'b1);
    m1 = step(m1, x1, 1'b1);
    m2 = step(m2, x2, 1'b0);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    iv = 1'b0; pre_en = 1'b0; swap = 1'b0; clr = 1'b0; drain0 = 1'b0; drain1 = 1'b0;
    i0 = '0; i1 = '0; i2 = '0; pre_data = '0;
  endtask

  task automatic reset_models();
    m0 = '{default: '0};
    m1 = '{default: '0};
    m2 = '{default: '0};
  endtask

  function automatic logic [DW-1:0] rnd_elem();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < L; i++) v[i*DW +: DW] = rnd_elem();
    return v;
  endfunction

  initial begin
    rst = 1'b1; sel = 2'b00;
    idle_in();
    reset_models();
    #3;
    check_all();
    @(negedge clk); rst = 1'b0;

    // WS single MAC
    pre_en = 1'b1; pre_data = pk(3, -2); tick();
    pre_en = 1'b0; swap = 1'b1; tick();
    swap = 1'b0; i2 = pk(5, 7); i1 = 100; iv = 1'b1; tick();
    cmp("ws_mac_out1", 64'(if0.output_1), 64'd101);
    cmp("ws_mac_out2", 64'(if0.output_2), 64'(pk(5, 7)));
    cmp("ws_mac_valid", 64'({if0.out_valid, if0.psum_valid, if0.output_0}), 64'({2'b11, 32'h0}));

    // Double buffer
    idle_in(); pre_en = 1'b1; pre_data = pk(1, 1); tick();
    pre_en = 1'b0; swap = 1'b1; tick();
    swap = 1'b0; pre_en = 1'b1; pre_data = pk(2, 2); i2 = pk(1, 1); i1 = 0; iv = 1'b1; tick();
    cmp("dbuf_preload", 64'(if0.output_1), 64'd2);
    pre_en = 1'b0; swap = 1'b1; tick();
    cmp("dbuf_swap_cycle", 64'(if0.output_1), 64'd2);
    swap = 1'b0; tick();
    cmp("dbuf_after_swap", 64'(if0.output_1), 64'd4);

    // Saturation and wrap
    idle_in(); pre_en = 1'b1; pre_data = pk(-32768, -32768); tick();
    pre_en = 1'b0; swap = 1'b1; tick();
    swap = 1'b0; i2 = pk(-32768, -32768); i1 = 32'h7FFF_FFFF; iv = 1'b1; tick();
    cmp("sat_clamp", 64'(if0.output_1), 64'h7FFF_FFFF);
    cmp("sat_flag", 64'(sat0), 64'd1);
    cmp("wrap_value", 64'(if2.output_1), 64'hFFFF_FFFF);
    cmp("wrap_flag", 64'(sat2), 64'd1);
    idle_in(); clr = 1'b1; tick();
    cmp("sat_clr", 64'({sat0, sat2}), 64'd0);

    // OS accumulate and skewed drain down the 2-PE column
    idle_in(); sel = 2'b10; tick();
    i0 = pk(1, 2); i2 = pk(3, 4); iv = 1'b1;
    tick();
    cmp("os_pass_out0", 64'(if0.output_0), 64'(pk(1, 2)));
    cmp("os_out1_zero", 64'({if0.output_1, if0.psum_valid}), 64'd0);
    tick(); tick();
    idle_in(); drain0 = 1'b1; tick();
    cmp("os_drain_u0", 64'({if0.psum_valid, if0.output_1}), 64'({1'b1, 32'd33}));
    drain1 = 1'b1; tick();
    cmp("os_drain_u1_a", 64'({if1.psum_valid, if1.output_1}), 64'({1'b1, 32'd33}));
    drain0 = 1'b0; tick();
    cmp("os_drain_u1_b", 64'({if1.psum_valid, if1.output_1}), 64'({1'b1, 32'd33}));
    drain0 = 1'b1; tick();
    cmp("os_empty_u0", 64'(if0.output_1), 64'd0);
    cmp("os_empty_u1", 64'(if1.output_1), 64'd0);

    // Priority: drain over clear over MAC
    idle_in(); i0 = pk(5, 0); i2 = pk(10, 0); iv = 1'b1; tick();
    drain0 = 1'b1; clr = 1'b1; i1 = 77; tick();
    cmp("prio_drain", 64'({if0.psum_valid, if0.output_1}), 64'({1'b1, 32'd50}));
    clr = 1'b0; iv = 1'b0; tick();
    cmp("prio_acc_in1", 64'(if0.output_1), 64'd77);

    // Mode change clears the accumulator
    idle_in(); sel = 2'b00; tick();
    sel = 2'b10; tick();
    drain0 = 1'b1; tick();
    cmp("mode_chg_clear", 64'(if0.output_1), 64'd0);

    // Asynchronous reset mid-accumulation
    idle_in(); i0 = pk(1, 2); i2 = pk(3, 4); iv = 1'b1; tick(); tick();
    #2; rst = 1'b1; #1;
    cmp("arst_out0", 64'(if0.output_0), 64'd0);
    reset_models();
    check_all();
    @(negedge clk); rst = 1'b0;
    iv = 1'b0; tick();
    iv = 1'b1; tick();
    idle_in(); drain0 = 1'b1; tick();
    cmp("arst_first_mac", 64'(if0.output_1), 64'd11);

    // Randomized segments across all modes
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) begin
        idle_in();
        sel = 2'($urandom_range(0, 3));
      end else begin
        iv       = 1'($urandom_range(0, 1));
        pre_en   = ($urandom_range(0, 3) == 0);
        swap     = ($urandom_range(0, 7) == 0);
        clr      = ($urandom_range(0, 15) == 0);
        drain0   = ($urandom_range(0, 5) == 0);
        drain1   = ($urandom_range(0, 5) == 0);
        pre_data = rnd_vec();
        i0       = rnd_vec();
        i2       = rnd_vec();
        i1       = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : AW'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
